// File: rtl/result_packer_pkg.sv
// Shared helpers for the result packer: requantize function and lane geometry.
package result_packer_pkg;

  // Working width for the shift/saturate arithmetic; wide enough for any OPREC below 64.
  localparam int unsigned SatW = 64;

  // Bits needed to index a lane; never less than one so a 1-lane build still has a counter.
  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Least-significant bit of lane k inside the packed word.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned prec);
    return lane * prec;
  endfunction

  // Arithmetic right shift (truncating toward -inf), then clamp to a signed prec-bit range.
  function automatic logic signed [SatW-1:0] sat_shift(input logic signed [SatW-1:0] val,
                                                       input int unsigned         shift,
                                                       input int unsigned         prec);
    logic signed [SatW-1:0] q;
    logic signed [SatW-1:0] max_v;
    logic signed [SatW-1:0] min_v;
    q     = val >>> shift;
    max_v = (64'sd1 <<< (prec - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (prec - 1));
    if (q > max_v) begin
      return max_v;
    end else if (q < min_v) begin
      return min_v;
    end
    return q;
  endfunction

endpackage

// File: rtl/result_packer_fifo.sv
// Synchronous word FIFO for the result packer. A push into a full FIFO is only
// accepted when a pop happens in the same cycle; otherwise the word is dropped
// and the caller is expected to flag it.
module packer_fifo #(
  parameter int unsigned Width = 513,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  next_count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CntW'(Depth));
  assign do_pop       = pop_i && !empty_o;
  // A full FIFO can still take a word if the head leaves in the same cycle.
  assign do_push      = push_i && (!full_o || do_pop);
  assign data_o       = mem_q[rd_ptr_q];
  assign next_count_o = count_d;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Pointers and occupancy; pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  // Storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/result_packer.sv
// Requantizes datapath results to IPREC bits, packs LANES of them per word and
// buffers words for a ready/valid consumer. The datapath cannot be stalled, so
// words arriving at a full FIFO are dropped and a sticky overflow flag is raised.
// DATAW must equal LANES*IPREC, FIFO_DEPTH must be a power of two, OPREC < 64.
module result_packer
  import result_packer_pkg::*;
#(
  parameter int unsigned LANES       = 64,
  parameter int unsigned DATAW       = 512,
  parameter int unsigned IPREC       = 8,
  parameter int unsigned OPREC       = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned AFULL_LEVEL = 2,
  parameter int unsigned SHIFTW      = $clog2(OPREC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [OPREC-1:0]  i_result,
  input  logic [SHIFTW-1:0] i_shift,
  input  logic              i_flush,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATAW-1:0]  o_data,
  output logic              o_last,
  output logic              o_almost_full,
  output logic              o_overflow
);

  localparam int unsigned LaneW    = lane_idx_w(LANES);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;

  // Stage 1: requantized element
  logic             s1_valid_q;
  logic             s1_flush_q;
  logic [IPREC-1:0] s1_data_q;
  logic [SatW-1:0]  result_ext;
  logic [SatW-1:0]  sat_full;

  // Stage 2: pack register and completed word
  logic [DATAW-1:0] pack_q;
  logic [DATAW-1:0] pack_next;
  logic [LaneW-1:0] cnt_q;
  logic             word_done;
  logic             word_valid_q;
  logic             word_last_q;
  logic [DATAW-1:0] word_q;

  // Stage 3: FIFO
  logic [DATAW:0]      fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [FifoCntW-1:0] fifo_next_count;
  logic                afull_q;
  logic                overflow_q;

  assign result_ext = SatW'($signed(i_result));
  assign sat_full   = sat_shift(result_ext, 32'(i_shift), IPREC);

  // Stage 1: shift and saturate each incoming element, carrying valid/flush along.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_flush_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= i_valid;
      s1_flush_q <= i_valid && i_flush;
      s1_data_q  <= sat_full[IPREC-1:0];
    end
  end

  // Insert the stage-1 element into its lane and decide whether the word closes.
  always_comb begin
    pack_next = pack_q;
    for (int k = 0; k < LANES; k++) begin
      if (cnt_q == LaneW'(k)) begin
        pack_next[lane_lsb(k, IPREC) +: IPREC] = s1_data_q;
      end
    end
    word_done = s1_valid_q && (s1_flush_q || (cnt_q == LaneW'(LANES - 1)));
  end

  // Stage 2: accumulate lanes; a closed word moves out and the pack register restarts empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q       <= '0;
      cnt_q        <= '0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      word_q       <= '0;
    end else begin
      word_valid_q <= word_done;
      if (s1_valid_q) begin
        if (word_done) begin
          word_q      <= pack_next;
          word_last_q <= s1_flush_q;
          pack_q      <= '0;
          cnt_q       <= '0;
        end else begin
          pack_q <= pack_next;
          cnt_q  <= cnt_q + LaneW'(1);
        end
      end
    end
  end

  assign fifo_pop = o_valid && i_ready;

  packer_fifo #(
    .Width (DATAW + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (word_valid_q),
    .data_i       ({word_last_q, word_q}),
    .pop_i        (fifo_pop),
    .data_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .next_count_o (fifo_next_count)
  );

  // Stall hint tracks post-update occupancy; overflow latches on any dropped word.
  always_ff @(posedge clk) begin
    if (rst) begin
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      afull_q <= (32'(fifo_next_count) >= AFULL_LEVEL);
      if (word_valid_q && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign o_valid       = !fifo_empty;
  // Mask stale storage so the bus reads zero while nothing is offered.
  assign o_data        = fifo_empty ? '0 : fifo_head[DATAW-1:0];
  assign o_last        = fifo_empty ? 1'b0 : fifo_head[DATAW];
  assign o_almost_full = afull_q;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_result_packer.sv
module tb_result_packer;

  localparam int unsigned Lanes = 4;
  localparam int unsigned Depth = 4;
  localparam int unsigned Afull = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_result = '0;
  logic [4:0]  i_shift = '0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_last;
  logic        o_almost_full;
  logic        o_overflow;

  int checks = 0;
  int failures = 0;

  result_packer #(
    .LANES       (4),
    .DATAW       (32),
    .IPREC       (8),
    .OPREC       (32),
    .FIFO_DEPTH  (4),
    .AFULL_LEVEL (2),
    .SHIFTW      (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_result      (i_result),
    .i_shift       (i_shift),
    .i_flush       (i_flush),
    .i_ready       (i_ready),
    .o_valid       (o_valid),
    .o_data        (o_data),
    .o_last        (o_last),
    .o_almost_full (o_almost_full),
    .o_overflow    (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: element stream -> words -> bounded queue, 2 edges from completion to FIFO.
  typedef struct {
    logic [31:0] data;
    bit          last;
    int          due;
  } word_t;

  word_t       mq[$];
  word_t       pend[$];
  logic [7:0]  lanes[Lanes];
  int          cnt = 0;
  int          cyc = 0;
  bit          ovf = 1'b0;
  bit          live = 1'b0;
  logic [31:0] popped[$];
  bit          popped_last[$];

  function automatic logic [7:0] requant(input logic [31:0] r, input logic [4:0] sh);
    longint v;
    v = longint'($signed(r)) >>> sh;
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return v[7:0];
  endfunction

  always @(posedge clk) begin : model
    word_t w;
    logic [31:0] word;
    bit pop;
    cyc++;
    if (rst) begin
      mq.delete();
      pend.delete();
      for (int k = 0; k < Lanes; k++) lanes[k] = '0;
      cnt  = 0;
      ovf  = 1'b0;
      live = 1'b1;
    end else begin
      pop = (mq.size() != 0) && i_ready;
      if (pop) void'(mq.pop_front());
      while (pend.size() != 0 && pend[0].due == cyc) begin
        w = pend.pop_front();
        if (mq.size() < Depth) mq.push_back(w);
        else ovf = 1'b1;
      end
      if (i_valid) begin
        lanes[cnt] = requant(i_result, i_shift);
        if (cnt == Lanes - 1 || i_flush) begin
          for (int k = 0; k < Lanes; k++) word[k*8 +: 8] = lanes[k];
          w.data = word;
          w.last = i_flush;
          w.due  = cyc + 2;
          pend.push_back(w);
          for (int k = 0; k < Lanes; k++) lanes[k] = '0;
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of words actually handed over.
  always @(negedge clk) begin
    if (live) begin
      chk("o_valid", 64'(o_valid), 64'(mq.size() != 0));
      chk("o_data", 64'(o_data), (mq.size() != 0) ? 64'(mq[0].data) : 64'd0);
      chk("o_last", 64'(o_last), (mq.size() != 0) ? 64'(mq[0].last) : 64'd0);
      chk("o_almost_full", 64'(o_almost_full), 64'(mq.size() >= Afull));
      chk("o_overflow", 64'(o_overflow), 64'(ovf));
      if (o_valid && i_ready && !rst) begin
        popped.push_back(o_data);
        popped_last.push_back(o_last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int val, input int sh, input bit fl);
    i_valid  = 1'b1;
    i_result = 32'(val);
    i_shift  = 5'(sh);
    i_flush  = fl;
    tick();
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_flush = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_log();
    popped.delete();
    popped_last.delete();
  endtask

  logic [31:0] t4_exp[4] = '{32'h04030201, 32'h08070605, 32'h0c0b0a09, 32'h100f0e0d};

  initial begin
    repeat (2) tick();
    chk("reset_o_valid", 64'(o_valid), 64'd0);
    chk("reset_o_data", 64'(o_data), 64'd0);
    rst = 1'b0;
    i_ready = 1'b1;

    // 1: plain pack and latency
    clear_log();
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0);
    i_valid = 1'b0;
    tick();
    chk("t1_not_yet_valid", 64'(o_valid), 64'd0);
    tick();
    chk("t1_valid_after_3", 64'(o_valid), 64'd1);
    idle(4);
    chk("t1_count", 64'(popped.size()), 64'd1);
    chk("t1_word", 64'(popped[0]), 64'h04030201);
    chk("t1_last", 64'(popped_last[0]), 64'd0);

    // 2: shift with saturation
    clear_log();
    send(1000, 2, 0); send(-1000, 2, 0); send(32'h100, 2, 0); send(-1, 2, 0);
    idle(6);
    chk("t2_count", 64'(popped.size()), 64'd1);
    chk("t2_word", 64'(popped[0]), 64'hff40807f);

    // 3: partial flush, then next vector restarts at lane 0
    clear_log();
    send(5, 0, 0); send(6, 0, 1);
    send(7, 0, 0); send(8, 0, 0); send(9, 0, 0); send(10, 0, 0);
    idle(6);
    chk("t3_count", 64'(popped.size()), 64'd2);
    chk("t3_word0", 64'(popped[0]), 64'h00000605);
    chk("t3_last0", 64'(popped_last[0]), 64'd1);
    chk("t3_word1", 64'(popped[1]), 64'h0a090807);
    chk("t3_last1", 64'(popped_last[1]), 64'd0);

    // 4: overflow under backpressure
    i_ready = 1'b0;
    for (int i = 1; i <= 24; i++) send(i, 0, 0);
    idle(4);
    chk("t4_overflow", 64'(o_overflow), 64'd1);
    chk("t4_almost_full", 64'(o_almost_full), 64'd1);
    clear_log();
    i_ready = 1'b1;
    idle(8);
    chk("t4_count", 64'(popped.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk("t4_word", 64'(popped[k]), 64'(t4_exp[k]));
    chk("t4_overflow_sticky", 64'(o_overflow), 64'd1);

    // 6: reset with a buffered word and a partial word in flight
    i_ready = 1'b0;
    send(21, 0, 0); send(22, 0, 0); send(23, 0, 0); send(24, 0, 0);
    send(31, 0, 0); send(32, 0, 0); send(33, 0, 0);
    idle(2);
    rst = 1'b1;
    tick();
    chk("t6_o_valid", 64'(o_valid), 64'd0);
    chk("t6_o_data", 64'(o_data), 64'd0);
    chk("t6_o_last", 64'(o_last), 64'd0);
    chk("t6_o_almost_full", 64'(o_almost_full), 64'd0);
    chk("t6_o_overflow", 64'(o_overflow), 64'd0);
    rst = 1'b0;
    i_ready = 1'b1;
    clear_log();
    send(9, 0, 0); send(10, 0, 0); send(11, 0, 0); send(12, 0, 0);
    idle(6);
    chk("t6_count", 64'(popped.size()), 64'd1);
    chk("t6_word", 64'(popped[0]), 64'h0c0b0a09);

    // 5: full FIFO, pop and push in the same cycle
    i_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(i, 0, 0);
    idle(4);
    chk("t5_full_af", 64'(o_almost_full), 64'd1);
    clear_log();
    send(17, 0, 0); send(18, 0, 0); send(19, 0, 0); send(20, 0, 0);
    i_valid = 1'b0;
    tick();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    idle(2);
    chk("t5_overflow", 64'(o_overflow), 64'd0);
    chk("t5_one_pop", 64'(popped.size()), 64'd1);
    chk("t5_first", 64'(popped[0]), 64'h04030201);
    i_ready = 1'b1;
    idle(8);
    chk("t5_count", 64'(popped.size()), 64'd5);
    chk("t5_newest", 64'(popped[4]), 64'h14131211);
    chk("t5_overflow_end", 64'(o_overflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
